// File: rtl/unlock_pkg.sv
// Shared types and width helpers for the password unlock path.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package unlock_pkg;

    // Top-level controller states
    typedef enum logic [1:0] {
        ACCEPT  = 2'd0,
        SHIFT   = 2'd1,
        REPORT  = 2'd2,
        LOCKOUT = 2'd3
    } state_t;

    // Symbol index width; at least one bit so LEN=1 still has a legal vector
    function automatic int sym_idx_w(input int len);
        return (len > 1) ? $clog2(len) : 1;
    endfunction

    // Bit counter width inside a symbol; at least one bit for N=1
    function automatic int bit_cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Lockout down-counter width; must hold the value LOCK_CYCLES itself
    function automatic int lock_cnt_w(input int lock_cycles);
        return (lock_cycles > 0) ? $clog2(lock_cycles + 1) : 1;
    endfunction

    // Failure counter width; must hold the value MAX_TRIES itself
    function automatic int fail_cnt_w(input int max_tries);
        return (max_tries > 0) ? $clog2(max_tries + 1) : 1;
    endfunction

endpackage

// File: rtl/unlock_sym_serializer.sv
// Accepts one N-bit symbol over valid/ready and streams it out MSB first, one bit per cycle.
// Latency: first bit valid the cycle after the handshake; last bit N cycles after it.
// Backpressure: p_ready follows accept_en from the controller; nothing is taken while bits are streaming.
module unlock_sym_serializer
    import unlock_pkg::*;
#(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         accept_en,
    input  logic [N-1:0] p_data,
    input  logic         p_valid,
    output logic         p_ready,
    output logic         sym_load,
    output logic         bit_dat,
    output logic         bit_vld,
    output logic         bit_last
);

    localparam int BW = bit_cnt_w(N);

    logic [N-1:0]  shreg;
    logic [BW-1:0] bit_cnt;
    logic          active;

    // The controller decides when a symbol may enter; the serializer only completes the handshake
    assign p_ready  = accept_en;
    assign sym_load = p_valid && accept_en;

    // Load on handshake, then shift one bit per cycle until the symbol is drained
    always_ff @(posedge clk) begin
        if (reset) begin
            shreg   <= '0;
            bit_cnt <= '0;
            active  <= 1'b0;
        end else if (sym_load) begin
            shreg   <= p_data;
            bit_cnt <= '0;
            active  <= 1'b1;
        end else if (active) begin
            shreg <= shreg << 1;
            if (bit_cnt == BW'(N - 1)) begin
                bit_cnt <= '0;
                active  <= 1'b0;
            end else begin
                bit_cnt <= bit_cnt + BW'(1);
            end
        end
    end

    assign bit_dat  = shreg[N-1];
    assign bit_vld  = active;
    assign bit_last = active && (bit_cnt == BW'(N - 1));

endmodule

// File: rtl/lockout_unlock_controller.sv
// Checks a streamed LEN-symbol password bit by bit against a key captured at attempt start; locks out after repeated failures.
// Latency: unlock/pwd_incorrect pulse N+1 cycles after the final symbol handshake; one symbol per N+1 cycles.
// Backpressure: p_ready only in ACCEPT; held low while shifting, reporting and for the whole lockout.
module lockout_unlock_controller
    import unlock_pkg::*;
#(
    parameter int N           = 4,
    parameter int LEN         = 4,
    parameter int MAX_TRIES   = 3,
    parameter int LOCK_CYCLES = 16
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic [N-1:0]                        p_data,
    input  logic                                p_valid,
    output logic                                p_ready,
    input  logic [N*LEN-1:0]                    pwd_key,
    output logic                                unlock,
    output logic                                pwd_incorrect,
    output logic                                locked_out,
    output logic [fail_cnt_w(MAX_TRIES)-1:0]    fail_cnt
);

    localparam int KW = N * LEN;
    localparam int SW = sym_idx_w(LEN);
    localparam int LW = lock_cnt_w(LOCK_CYCLES);
    localparam int FW = fail_cnt_w(MAX_TRIES);

    state_t         state;
    logic [KW-1:0]  key_q;
    logic [SW-1:0]  sym_idx;
    logic [LW-1:0]  lock_cnt;
    logic           mismatch;

    logic           sym_load;
    logic           bit_dat;
    logic           bit_vld;
    logic           bit_last;
    logic           bit_miss;
    logic           sym_final;

    unlock_sym_serializer #(
        .N (N)
    ) u_ser (
        .clk       (clk),
        .reset     (reset),
        .accept_en (state == ACCEPT),
        .p_data    (p_data),
        .p_valid   (p_valid),
        .p_ready   (p_ready),
        .sym_load  (sym_load),
        .bit_dat   (bit_dat),
        .bit_vld   (bit_vld),
        .bit_last  (bit_last)
    );

    // The key register shifts in step with the data, so its MSB is always the bit under test
    assign bit_miss  = bit_dat != key_q[KW-1];
    assign sym_final = sym_idx == SW'(LEN - 1);

    // Attempt FSM: key capture, sticky mismatch, verdict pulses, failure count and lockout timer
    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= ACCEPT;
            key_q         <= '0;
            sym_idx       <= '0;
            mismatch      <= 1'b0;
            lock_cnt      <= '0;
            unlock        <= 1'b0;
            pwd_incorrect <= 1'b0;
            locked_out    <= 1'b0;
            fail_cnt      <= '0;
        end else begin
            unlock        <= 1'b0;
            pwd_incorrect <= 1'b0;
            case (state)
                ACCEPT: begin
                    if (sym_load) begin
                        state <= SHIFT;
                        // Key is frozen for the whole attempt so late key writes cannot skew it
                        if (sym_idx == '0) begin
                            key_q    <= pwd_key;
                            mismatch <= 1'b0;
                        end
                    end
                end
                SHIFT: begin
                    if (bit_vld) begin
                        key_q <= key_q << 1;
                        if (bit_miss) begin
                            mismatch <= 1'b1;
                        end
                        if (bit_last) begin
                            if (sym_final) begin
                                sym_idx <= '0;
                                state   <= REPORT;
                                // Verdict includes the bit being checked this cycle
                                if (mismatch || bit_miss) begin
                                    pwd_incorrect <= 1'b1;
                                    fail_cnt      <= (fail_cnt == FW'(MAX_TRIES)) ? fail_cnt
                                                                                  : fail_cnt + FW'(1);
                                end else begin
                                    unlock   <= 1'b1;
                                    fail_cnt <= '0;
                                end
                            end else begin
                                sym_idx <= sym_idx + SW'(1);
                                state   <= ACCEPT;
                            end
                        end
                    end
                end
                REPORT: begin
                    if (fail_cnt == FW'(MAX_TRIES)) begin
                        state      <= LOCKOUT;
                        locked_out <= 1'b1;
                        lock_cnt   <= LW'(LOCK_CYCLES);
                    end else begin
                        state <= ACCEPT;
                    end
                end
                LOCKOUT: begin
                    // Counter holds the remaining lockout cycles including the current one
                    if (lock_cnt <= LW'(1)) begin
                        lock_cnt   <= '0;
                        locked_out <= 1'b0;
                        fail_cnt   <= '0;
                        state      <= ACCEPT;
                    end else begin
                        lock_cnt <= lock_cnt - LW'(1);
                    end
                end
                default: begin
                    state <= ACCEPT;
                end
            endcase
        end
    end

endmodule

// File: doc/lockout_unlock_controller.md
# lockout_unlock_controller

Parametrised successor to the integrated P2S + Mealy unlocking path. It accepts a password as a stream of N-bit symbols over a valid/ready handshake and serialises each symbol internally. Each bit is checked against a programmable LEN-symbol key, and the block reports unlock or incorrect once per complete attempt. Consecutive failures are counted, and after MAX_TRIES failures all input is refused for a timed lockout.

## Interface
- N, 4: symbol width in bits (≥1)
- LEN, 4: symbols per password (≥1)
- MAX_TRIES, 3: consecutive failed attempts that trigger lockout (≥1)
- LOCK_CYCLES, 16: lockout duration in clock cycles (≥1)
- clk  in  1  single clock, all logic on rising edge
- reset  in  1  synchronous, active-high reset
- p_data  in  N  password symbol
- p_valid  in  1  p_data valid; sender holds p_data/p_valid until handshake
- p_ready  out  1  block can accept a symbol
- pwd_key  in  N*LEN  expected password; symbol 0 = bits [N*LEN-1 -: N]
- unlock  out  1  one-cycle pulse, attempt correct
- pwd_incorrect  out  1  one-cycle pulse, attempt wrong
- locked_out  out  1  high for the whole lockout
- fail_cnt  out  $clog2(MAX_TRIES+1)  consecutive failures so far

## Operation
- States: ACCEPT, SHIFT, REPORT, LOCKOUT. Reset state is ACCEPT.
- ACCEPT:
  - p_ready=1.
  - On p_valid&&p_ready, load p_data into the shift register and go to SHIFT.
  - On the first symbol of an attempt (sym_idx==0), capture pwd_key into a key register and clear the mismatch flag.
  - pwd_key changes mid-attempt have no effect.
- SHIFT:
  - p_ready=0. Runs exactly N cycles and consumes one bit per cycle, MSB first.
  - Compares each bit with the matching key bit. Any mismatch sets the sticky mismatch flag.
  - There is no early abort: every attempt consumes all LEN symbols.
  - After bit N: if sym_idx==LEN-1, clear sym_idx and go to REPORT. Otherwise increment sym_idx and go to ACCEPT.
- REPORT, one cycle, p_ready=0:
  - Mismatch clear: unlock=1, fail_cnt←0, then ACCEPT.
  - Mismatch set: pwd_incorrect=1 and fail_cnt←fail_cnt+1.
  - If the new fail_cnt==MAX_TRIES, go to LOCKOUT. Otherwise go to ACCEPT.
- LOCKOUT:
  - p_ready=0, locked_out=1. A down-counter is loaded with LOCK_CYCLES.
  - p_valid is ignored.
  - When the counter expires: fail_cnt←0, go to ACCEPT.
- fail_cnt saturates at MAX_TRIES and never wraps.

## Timing
- All outputs other than p_ready are registered. p_ready is decoded from state==ACCEPT.
- Reset values: p_ready=1 in the first cycle after reset. unlock=0, pwd_incorrect=0, locked_out=0, fail_cnt=0, sym_idx=0, mismatch=0.
- A handshake that coincides with reset is discarded.
- Throughput: one symbol per N+1 cycles.
  - Non-final symbol handshake at cycle t: p_ready high again at t+N+1.
  - Final symbol handshake at cycle t: unlock or pwd_incorrect high in cycle t+N+1 only. p_ready returns at t+N+2, or after lockout.
- Lockout: locked_out is high for exactly LOCK_CYCLES cycles, starting the cycle after the REPORT that triggered it. p_ready=1 in the following cycle, with fail_cnt=0.
- unlock and pwd_incorrect are never high together.
- Reset mid-attempt or mid-lockout discards the partial attempt, clears fail_cnt and the lockout, and raises no pulse.

## Structure
- Package unlock_pkg holds:
  - the state typedef enum {ACCEPT, SHIFT, REPORT, LOCKOUT};
  - width helper functions for sym_idx ($clog2(LEN)), bit counter ($clog2(N)), lockout counter ($clog2(LOCK_CYCLES+1)) and fail_cnt.
- One sub-module, unlock_sym_serializer, with parameter N. It owns the valid/ready side, the shift register and the bit counter. It exposes a serial bit, a bit-valid strobe and a last-bit flag.
- The top level holds the FSM, key register, comparator, fail counter and lockout counter.

## Test plan
- N=4, LEN=4, key 16'hA5C3; send A,5,C,3 back-to-back -> unlock pulse exactly 5 cycles after the 4th handshake, width 1; fail_cnt stays 0.
- Same key; send A,5,C,2 -> pwd_incorrect pulse only after the 4th symbol, never earlier; fail_cnt=1; p_ready back the cycle after the pulse.
- Three wrong attempts -> third pwd_incorrect, then locked_out=1 for 16 cycles with p_ready=0 while p_valid is held high and not accepted; then fail_cnt=0, p_ready=1.
- Two wrong attempts then A,5,C,3 -> unlock; fail_cnt goes 2 to 0; no lockout.
- Reset asserted after 2 symbols accepted -> all outputs at reset values, no pulse; a following full correct attempt unlocks.
- Change pwd_key to 16'h0000 after the first symbol of A,5,C,3 -> unlock still pulses. Toggle p_valid during SHIFT -> no extra symbol is consumed.
